// File: rtl/lc3_fetch_ctrl.sv
// LC-3 fetch controller: owns the PC, resolves BR/JMP/JSR(R) targets
// and issues a read-only instruction fetch held for MEM_LAT cycles.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   fetch_start        : fetch request, accepted only in IDLE
//   opCode_in          : opcode of the instruction just executed
//   offset_in          : PCoffset11 (BR uses [8:0])
//   jsr_mode           : 1 = JSR (offset), 0 = JSRR (reg_in)
//   reg_in             : BaseR value for JMP/JSRR
//   br_nzp, result_nzp : BR condition bits, current condition codes
//   stall              : memory not ready, freezes the WAIT counter
//   addr_out, wea_out  : instruction memory address, write enable (0)
//   pc                 : program counter
//   busy               : fetch in flight
//   ir_valid           : one-cycle pulse, instruction word valid
//   r7_out, r7_we      : R7 link value and one-cycle write strobe
module lc3_fetch_ctrl #(
  parameter int ADDR_W = 16,
  parameter int MEM_LAT = 1,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic [3:0]        opCode_in,
  input  logic [10:0]       offset_in,
  input  logic              jsr_mode,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wea_out,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] r7_out,
  output logic              r7_we
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] r7_q, r7_d;
  logic              r7we_q, r7we_d;
  logic              irv_q, irv_d;

  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jsr_off;
  logic [ADDR_W-1:0] target;
  logic              is_br;
  logic              is_jsr;
  logic              is_jmp;
  logic              taken;

  assign br_off  = {{(ADDR_W-9){offset_in[8]}}, offset_in[8:0]};
  assign jsr_off = {{(ADDR_W-11){offset_in[10]}}, offset_in};
  assign is_br   = (opCode_in == OP_BR);
  assign is_jsr  = (opCode_in == OP_JSR);
  assign is_jmp  = (opCode_in == OP_JMP);
  assign taken   = |(br_nzp & result_nzp);

  always_comb begin
    target = pc_q;
    unique case (1'b1)
      is_br:   target = taken ? pc_q + br_off : pc_q;
      is_jmp:  target = reg_in;
      is_jsr:  target = jsr_mode ? pc_q + jsr_off : reg_in;
      default: target = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    r7_d    = r7_q;
    r7we_d  = 1'b0;
    irv_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_start) begin
          pc_d    = target;
          addr_d  = target;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
          if (is_jsr) begin
            r7_d   = pc_q;
            r7we_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!stall) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            // Word is at the memory output: advance past it.
            pc_d    = pc_q + ADDR_W'(1);
            irv_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= PC_RESET;
      addr_q  <= '0;
      r7_q    <= '0;
      r7we_q  <= 1'b0;
      irv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      r7_q    <= r7_d;
      r7we_q  <= r7we_d;
      irv_q   <= irv_d;
    end
  end

  assign addr_out = addr_q;
  assign wea_out  = 1'b0;
  assign pc       = pc_q;
  assign busy     = (state_q != IDLE);
  assign ir_valid = irv_q;
  assign r7_out   = r7_q;
  assign r7_we    = r7we_q;

endmodule
